// File: rtl/noc_arb_pkg.sv
// Shared helpers for the NoC output-port arbiters: pointer rotation, one-hot decode, reset pointer.
package noc_arb_pkg;

    localparam int MAX_N = 32;
    localparam int IDX_W = 5;
    localparam logic [MAX_N-1:0] PRIO_RST = 'b1;

    // Rotate left by one within the low n bits; bit n-1 wraps to bit 0.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] vec, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 1; i < MAX_N; i++) begin
            if (i < n) r[i] = vec[i-1];
        end
        for (int i = 0; i < MAX_N; i++) begin
            if (i == n - 1) r[0] = vec[i];
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fpa_smart.sv
// Fixed-priority encoder: keeps only the lowest-index set bit of req.
module fpa_smart #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + ONE);

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin N:1 arbiter with wormhole packet locking.
// Optional forced unlock after an idle locked period: define RR_ARB_LOCK_TIMEOUT_EN.
module rr_lock_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N            = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request,
    input  logic         update,
    input  logic         last,
    output logic [N-1:0] grant,
    output logic         anygrant,
    output logic         locked
`ifdef RR_ARB_LOCK_TIMEOUT_EN
    ,
    output logic         timeout_pulse
`endif
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > MAX_N || LOCK_TIMEOUT < 1) begin : g_bad_param
        $error("rr_lock_arbiter: N must be 2..MAX_N and LOCK_TIMEOUT >= 1");
    end

    function automatic logic [N-1:0] rot_n(input logic [N-1:0] v);
        return N'(rotl1(MAX_N'(v), N));
    endfunction

    logic [N-1:0] prio_q, prio_d;
    logic [N-1:0] lock_vec_q, lock_vec_d;
    logic         locked_q, locked_d;
    logic [N-1:0] mask, mreq, gnt_masked, gnt_unmasked, arb_grant;

    assign mask = ~(prio_q - ONE);
    assign mreq = request & mask;

    fpa_smart #(.N(N)) u_fpa_masked   (.req(mreq),    .gnt(gnt_masked));
    fpa_smart #(.N(N)) u_fpa_unmasked (.req(request), .gnt(gnt_unmasked));

    // Grant depends only on request and registered state, never on update/last.
    always_comb begin
        arb_grant = (|mreq) ? gnt_masked : gnt_unmasked;
        grant     = locked_q ? (request & lock_vec_q) : arb_grant;
    end

    assign anygrant = |grant;
    assign locked   = locked_q;

`ifdef RR_ARB_LOCK_TIMEOUT_EN
    localparam int TW = ($clog2(LOCK_TIMEOUT + 1) > 8) ? $clog2(LOCK_TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_pulse_q, timeout_pulse_d;
    logic          tmo_fire;

    assign timeout_pulse = timeout_pulse_q;
`endif

    always_comb begin
        prio_d     = prio_q;
        lock_vec_d = lock_vec_q;
        locked_d   = locked_q;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
        tmo_cnt_d  = '0;
        tmo_fire   = 1'b0;
        if (locked_q && !anygrant) begin
            if (tmo_cnt_q == TW'(LOCK_TIMEOUT - 1)) tmo_fire = 1'b1;
            else                                     tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        timeout_pulse_d = tmo_fire;
`endif
        if (update && anygrant) begin
            if (!locked_q) begin
                if (!last) begin
                    locked_d   = 1'b1;
                    lock_vec_d = grant;
                end else begin
                    prio_d = rot_n(grant);
                end
            end else if (last) begin
                locked_d   = 1'b0;
                lock_vec_d = '0;
                prio_d     = rot_n(lock_vec_q);
            end
        end
`ifdef RR_ARB_LOCK_TIMEOUT_EN
        else if (tmo_fire) begin
            locked_d   = 1'b0;
            lock_vec_d = '0;
            prio_d     = rot_n(lock_vec_q);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= N'(PRIO_RST);
            lock_vec_q <= '0;
            locked_q   <= 1'b0;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
            prio_q     <= prio_d;
            lock_vec_q <= lock_vec_d;
            locked_q   <= locked_d;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed self-checking bench for rr_lock_arbiter (N=4, LOCK_TIMEOUT=4).
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] request;
    logic       update;
    logic       last;
    logic [3:0] grant;
    logic       anygrant;
    logic       locked;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
    logic       timeout_pulse;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.N(4), .LOCK_TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .request  (request),
        .update   (update),
        .last     (last),
        .grant    (grant),
        .anygrant (anygrant),
        .locked   (locked)
`ifdef RR_ARB_LOCK_TIMEOUT_EN
        ,
        .timeout_pulse (timeout_pulse)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] exp);
        chk(tag, 32'(grant), 32'(exp));
        chk({tag, "_any"}, 32'(anygrant), 32'(|exp));
    endtask

    task automatic drive(input logic [3:0] req, input logic upd, input logic lst);
        request = req;
        update  = upd;
        last    = lst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp1 [5];
        exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_grant("reset_grant", 4'b0000);
        chk("reset_locked", 32'(locked), 32'd0);
`ifdef RR_ARB_LOCK_TIMEOUT_EN
        chk("reset_pulse", 32'(timeout_pulse), 32'd0);
`endif

        // 1: single-flit packets rotate through all inputs and wrap
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1, 1'b1);
            chk_grant($sformatf("rr_step%0d", i), exp1[i]);
            chk($sformatf("rr_locked%0d", i), 32'(locked), 32'd0);
            tick();
        end

        // 2: pointer at 2, only low requests -> unmasked fallback
        drive(4'b0010, 1'b1, 1'b1);
        chk_grant("wrap_setup", 4'b0010);
        tick();
        drive(4'b0011, 1'b1, 1'b1);
        chk_grant("wrap_unmasked", 4'b0001);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("wrap_prio_after", 4'b0010);

        // 3: multi-flit packet holds grant until tail
        drive(4'b1000, 1'b1, 1'b1);
        chk_grant("lock_setup", 4'b1000);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk_grant($sformatf("lock_body%0d", i), 4'b0001);
            chk($sformatf("lock_flag%0d", i), 32'(locked), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("lock_hold", 4'b0001);
        chk("lock_hold_flag", 32'(locked), 32'd1);
        drive(4'b1111, 1'b1, 1'b1);
        chk_grant("lock_tail", 4'b0001);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("after_tail", 4'b0010);
        chk("after_tail_flag", 32'(locked), 32'd0);

        // 4: locked on 2, request drops, update without grant ignored
        drive(4'b0100, 1'b1, 1'b0);
        chk_grant("drop_lock", 4'b0100);
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        chk_grant("drop_idle0", 4'b0000);
        chk("drop_flag0", 32'(locked), 32'd1);
        tick();
        drive(4'b0000, 1'b1, 1'b1);
        chk_grant("drop_idle1", 4'b0000);
        tick();
        chk("drop_flag1", 32'(locked), 32'd1);
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("drop_resume", 4'b0100);
        drive(4'b1111, 1'b1, 1'b1);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("drop_next", 4'b1000);

        // 5: reset mid-packet drops lock and restores pointer
        drive(4'b1111, 1'b1, 1'b0);
        chk_grant("rst_lock", 4'b1000);
        tick();
        chk("rst_locked_before", 32'(locked), 32'd1);
        rst = 1'b1;
        drive(4'b1111, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(4'b1010, 1'b0, 1'b0);
        chk("rst_locked_after", 32'(locked), 32'd0);
        chk_grant("rst_grant", 4'b0010);

        // update with no grant leaves pointer and lock alone
        drive(4'b0000, 1'b1, 1'b1);
        tick();
        drive(4'b0000, 1'b1, 1'b0);
        tick();
        chk("noop_locked", 32'(locked), 32'd0);
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("noop_prio", 4'b0001);

`ifdef RR_ARB_LOCK_TIMEOUT_EN
        // 6: locked on 1, four idle cycles force an unlock
        drive(4'b0010, 1'b1, 1'b0);
        chk_grant("tmo_lock", 4'b0010);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, 1'b0, 1'b0);
            chk($sformatf("tmo_locked%0d", i), 32'(locked), 32'd1);
            chk($sformatf("tmo_pulse%0d", i), 32'(timeout_pulse), 32'd0);
            tick();
        end
        chk("tmo_unlocked", 32'(locked), 32'd0);
        chk("tmo_pulse_hi", 32'(timeout_pulse), 32'd1);
        drive(4'b1111, 1'b0, 1'b0);
        chk_grant("tmo_prio", 4'b0100);
        tick();
        chk("tmo_pulse_lo", 32'(timeout_pulse), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
